sum_sequencer: RTL and testbench

- Frame-based accumulation controller that time-shares one combinational saturating adder to sum N_TERMS signed samples per frame.
- Samples arrive through a valid/ready handshake. The result is held on a registered output with a valid/ready handshake.
- Sits between the sample source (ADC/filter tap stage) and the downstream consumer in the fixed-point datapath.

---
 rtl/sum_sequencer_pkg.sv | 19 +
 rtl/sum_sequencer_if.sv | 25 ++
 rtl/sum_sequencer_satadd.sv | 37 +++
 rtl/sum_sequencer.sv | 112 +++++++++++
 tb/tb_sum_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sum_sequencer_pkg.sv
// Shared FSM encoding and saturation limits for the frame accumulator.
// Limits are symmetric, so a clamp never produces the most negative code.
package sum_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -sat_max(width);
  endfunction

endpackage

// File: rtl/sum_sequencer_if.sv
// Sample-in / result-out handshake bundle for sum_sequencer.
// The master drives samples and acknowledges results; the slave is the accumulator.
interface sum_sequencer_if #(
  parameter int Width = 22
);
  logic                    start;
  logic                    in_valid;
  logic signed [Width-1:0] in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [Width-1:0] out_data;
  logic                    sat_flag;
  logic                    busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sat_flag, busy
  );
endinterface

// File: rtl/sum_sequencer_satadd.sv
// Combinational signed saturating adder with symmetric clamp; zero latency.
// No handshake: sat is high whenever the raw sum overflowed and y was clamped.
module sum_sequencer_satadd
  import sum_sequencer_pkg::*;
#(
  parameter int Width = 22
) (
  input  logic signed [Width-1:0] a,
  input  logic signed [Width-1:0] b,
  output logic signed [Width-1:0] y,
  output logic                    sat
);

  localparam logic signed [Width-1:0] SAT_MAX = Width'(sat_max(Width));
  localparam logic signed [Width-1:0] SAT_MIN = Width'(sat_min(Width));

  logic signed [Width-1:0] raw;
  logic                    pos_ovf;
  logic                    neg_ovf;

  assign raw     = a + b;
  assign pos_ovf = !a[Width-1] && !b[Width-1] &&  raw[Width-1];
  assign neg_ovf =  a[Width-1] &&  b[Width-1] && !raw[Width-1];

  always_comb begin
    y   = raw;
    sat = 1'b0;
    if (pos_ovf) begin
      y   = SAT_MAX;
      sat = 1'b1;
    end else if (neg_ovf) begin
      y   = SAT_MIN;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/sum_sequencer.sv
// Sums N_TERMS saturated samples per frame; out_valid rises the cycle after the last accept.
// in_ready only in ACCUM; the result is held in DONE until out_ready, no combinational paths.
module sum_sequencer
  import sum_sequencer_pkg::*;
#(
  parameter int Width   = 22,
  parameter int N_TERMS = 4
) (
  input  logic clk,
  input  logic reset_n,
  sum_sequencer_if.slave bus
);

  localparam int CntW = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
  localparam logic [CntW-1:0] LAST_CNT = CntW'(N_TERMS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [Width-1:0] acc;
  logic signed [Width-1:0] sum;
  logic                    add_sat;
  logic [CntW-1:0]         count;
  logic signed [Width-1:0] out_data_q;
  logic                    sat_flag_q;
  logic                    accept;
  logic                    last;
  logic                    in_ready_d;
  logic                    out_valid_d;
  logic                    busy_d;

  sum_sequencer_satadd #(.Width(Width)) u_satadd (
    .a   (acc),
    .b   (bus.in_data),
    .y   (sum),
    .sat (add_sat)
  );

  assign accept = (state == ACCUM) && bus.in_valid;
  assign last   = accept && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are pure state decodes so nothing combinational reaches the ports.
  always_comb begin
    state_nxt   = state;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc        <= '0;
      count      <= '0;
      out_data_q <= '0;
      sat_flag_q <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        acc        <= '0;
        count      <= '0;
        sat_flag_q <= 1'b0;
      end
    end else if (accept) begin
      // A clamped sum is a normal operand for the next add, so acc may recover.
      acc   <= sum;
      count <= count + 1'b1;
      if (add_sat) begin
        sat_flag_q <= 1'b1;
      end
      if (last) begin
        out_data_q <= sum;
      end
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_d;
  assign bus.busy      = busy_d;
  assign bus.out_data  = out_data_q;
  assign bus.sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_sum_sequencer.sv
// Scoreboard bench for sum_sequencer: directed frames plus random frames against a clamped-sum model.
module tb_sum_sequencer;

  localparam int W    = 22;
  localparam int N    = 4;
  localparam int MAXV = 2097151;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sum_sequencer_if #(.Width(W)) bus ();

  sum_sequencer #(.Width(W), .N_TERMS(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  bit sat_q[$];
  int smp[N];
  int gap[N];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: pops the expected frame sum on each completed output handshake.
  always @(negedge clk) begin
    int  e;
    bit  s;
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got out_data %0d expected no result", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        s = sat_q.pop_front();
        check("out_data", $signed(bus.out_data), e);
        check("sat_flag", bus.sat_flag, s);
      end
    end
  end

  function automatic int rand_sample();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 2000)) - 1000;
      1:       return int'($urandom_range(0, 197151)) + 1900000;
      2:       return -(int'($urandom_range(0, 197151)) + 1900000);
      default: return int'($urandom_range(0, 4194303)) - 2097152;
    endcase
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_in_ready"},  bus.in_ready, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  $signed(bus.out_data), 0);
    check({tag, "_sat_flag"},  bus.sat_flag, 0);
  endtask

  task automatic run_frame(input int stall, input bit start_accum, input bit start_done);
    int acc;
    int s;
    int w;
    bit sat;
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = acc + smp[i];
      if (s > MAXV) begin
        s   = MAXV;
        sat = 1'b1;
      end else if (s < -MAXV - 1) begin
        s   = -MAXV;
        sat = 1'b1;
      end
      acc = s;
    end

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = W'(smp[i]);
      bus.start    = start_accum && (i == 1);
      check("in_ready_accum", bus.in_ready, 1);
      check("out_valid_early", bus.out_valid, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    exp_q.push_back(acc);
    sat_q.push_back(sat);

    w = 0;
    while (bus.out_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("result_latency", w, 0);
    for (int k = 0; k < stall; k++) begin
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", $signed(bus.out_data), acc);
      check("stall_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.start     = start_done;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("idle_after_ack", bus.busy, 0);
    check("out_data_hold", $signed(bus.out_data), acc);
  endtask

  task automatic set_frame(input int a, input int b, input int c, input int d);
    smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
    for (int i = 0; i < N; i++) gap[i] = 0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    tick();
    tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();

    set_frame(100, -30, 7, 1000);
    run_frame(0, 1'b0, 1'b0);

    set_frame(2000000, 200000, -50, 0);
    run_frame(0, 1'b0, 1'b0);

    set_frame(-2097152, -1, 0, 0);
    run_frame(1, 1'b0, 1'b0);

    set_frame(100, -30, 7, 1000);
    gap[1] = 3;
    gap[2] = 1;
    run_frame(3, 1'b0, 1'b0);

    // Abort a frame after two samples; it must leave no result and no residue.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(500 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    tick();
    reset_n      = 1'b1;
    check_idle_zero("midframe_reset");
    tick();
    set_frame(1, 2, 3, 4);
    run_frame(0, 1'b0, 1'b0);

    set_frame(rand_sample(), rand_sample(), rand_sample(), rand_sample());
    run_frame(1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("no_chain_after_done", bus.busy, 0);
      tick();
    end

    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        smp[i] = rand_sample();
        gap[i] = $urandom_range(0, 3);
      end
      repeat ($urandom_range(0, 2)) tick();
      run_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
